// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - shared definitions for the RV32M divide sequencer
// Contents: default operand width, funct3 encodings for the divide group, FSM state type.
package div_sequencer_pkg;

  localparam int DS_XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_RUN  = 2'd1,
    DS_DONE = 2'd2
  } ds_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract divide step
// Ports:
//   rem      in  W  partial remainder (always < divisor)
//   quo      in  W  dividend bits still to consume (MSB first) with quotient bits filling from LSB
//   divisor  in  W  magnitude of the divisor
//   rem_next out W  partial remainder after this step
//   quo_next out W  quo shifted left by one with the new quotient bit in LSB
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // rem < divisor keeps shifted below 2*divisor, so bit W of the
  // difference is a clean borrow flag.
  always_comb begin
    shifted = {rem, quo[W-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[W]) begin
      rem_next = diff[W-1:0];
      quo_next = {quo[W-2:0], 1'b1};
    end else begin
      rem_next = shifted[W-1:0];
      quo_next = {quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle DIV/DIVU/REM/REMU sequencer for the Execute stage
// Ports:
//   clk_i     in   1     clock
//   reset_i   in   1     synchronous reset, active-high
//   req_i     in   1     divide op present in Execute with valid operands
//   funct3_i  in   3     DIV/DIVU/REM/REMU select
//   rs1_i     in   XLEN  dividend
//   rs2_i     in   XLEN  divisor
//   stall_i   in   1     result not consumed this cycle
//   flush_i   in   1     kill the in-flight op
//   busy_o    out  1     divide share of the Execute busy/stall
//   done_o    out  1     result_o valid
//   result_o  out  XLEN  sign-corrected quotient or remainder
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int XLEN   = DS_XLEN,
  parameter int UNROLL = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            req_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);

  ds_state_e       state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] rem_q, quo_q, divisor_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic            neg_quo_q, neg_rem_q, is_rem_q, signed_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic            cache_valid, cache_signed;
  logic [XLEN-1:0] cache_rs1, cache_rs2, cache_quo, cache_rem;

  // Decode of the incoming request
  logic            op_valid, in_signed, in_rem, rs1_neg, rs2_neg;
  logic            div_zero, overflow, cache_hit, special;
  logic [XLEN-1:0] abs_rs1, abs_rs2, special_res;

  assign op_valid  = req_i & funct3_i[2];
  assign in_signed = ~funct3_i[0];
  assign in_rem    = funct3_i[1];
  assign rs1_neg   = in_signed & rs1_i[XLEN-1];
  assign rs2_neg   = in_signed & rs2_i[XLEN-1];
  assign abs_rs1   = rs1_neg ? -rs1_i : rs1_i;
  assign abs_rs2   = rs2_neg ? -rs2_i : rs2_i;

  assign div_zero  = (rs2_i == '0);
  assign overflow  = in_signed & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
  assign cache_hit = cache_valid & (rs1_i == cache_rs1) & (rs2_i == cache_rs2)
                   & (in_signed == cache_signed);
  assign special   = div_zero | overflow | cache_hit;

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = in_rem ? rs1_i : '1;
    else if (overflow)
      special_res = in_rem ? '0 : rs1_i;
    else
      special_res = in_rem ? cache_rem : cache_quo;
  end

  // UNROLL restoring steps per cycle
  logic [XLEN-1:0] rem_ch [UNROLL+1];
  logic [XLEN-1:0] quo_ch [UNROLL+1];

  assign rem_ch[0] = rem_q;
  assign quo_ch[0] = quo_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    div_step #(.W(XLEN)) u_step (
      .rem      (rem_ch[g]),
      .quo      (quo_ch[g]),
      .divisor  (divisor_q),
      .rem_next (rem_ch[g+1]),
      .quo_next (quo_ch[g+1])
    );
  end

  logic [XLEN-1:0] quo_fix, rem_fix;
  assign quo_fix = neg_quo_q ? -quo_ch[UNROLL] : quo_ch[UNROLL];
  assign rem_fix = neg_rem_q ? -rem_ch[UNROLL] : rem_ch[UNROLL];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= DS_IDLE;
      count        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      divisor_q    <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      is_rem_q     <= 1'b0;
      signed_q     <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      cache_valid  <= 1'b0;
      cache_signed <= 1'b0;
      cache_rs1    <= '0;
      cache_rs2    <= '0;
      cache_quo    <= '0;
      cache_rem    <= '0;
    end else if (flush_i) begin
      state    <= DS_IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        DS_IDLE: begin
          if (op_valid) begin
            if (special) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state    <= DS_DONE;
            end else begin
              rem_q     <= '0;
              quo_q     <= abs_rs1;
              divisor_q <= abs_rs2;
              rs1_q     <= rs1_i;
              rs2_q     <= rs2_i;
              neg_quo_q <= rs1_neg ^ rs2_neg;
              neg_rem_q <= rs1_neg;
              is_rem_q  <= in_rem;
              signed_q  <= in_signed;
              count     <= CW'(STEPS);
              state     <= DS_RUN;
            end
          end
        end
        DS_RUN: begin
          rem_q <= rem_ch[UNROLL];
          quo_q <= quo_ch[UNROLL];
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            result_q     <= is_rem_q ? rem_fix : quo_fix;
            done_q       <= 1'b1;
            state        <= DS_DONE;
            cache_valid  <= 1'b1;
            cache_signed <= signed_q;
            cache_rs1    <= rs1_q;
            cache_rs2    <= rs2_q;
            cache_quo    <= quo_fix;
            cache_rem    <= rem_fix;
          end
        end
        DS_DONE: begin
          // A req_i still asserted here is the same instruction; only consumption matters.
          if (!stall_i) begin
            done_q <= 1'b0;
            state  <= DS_IDLE;
          end
        end
        default: begin
          done_q <= 1'b0;
          state  <= DS_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = (state == DS_RUN) | ((state == DS_IDLE) & req_i);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed self-checking bench for div_sequencer
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [2:0]  funct3 = F3_DIV;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div_sequencer #(.XLEN(32), .UNROLL(1)) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .req_i    (req),
    .funct3_i (funct3),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .stall_i  (stall),
    .flush_i  (flush),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse req for one cycle, scramble operands while the op runs, wait for done_o.
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt, output logic [31:0] res);
    funct3 = f3;
    rs1 = a;
    rs2 = b;
    req = 1'b1;
    #1;
    busy_cnt = busy ? 1 : 0;
    tick();
    req = 1'b0;
    rs1 = $urandom;
    rs2 = $urandom;
    funct3 = 3'($urandom_range(4, 7));
    lat = 1;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    res = result;
  endtask

  task automatic consume();
    stall = 1'b0;
    tick();
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int lat, bc;
    logic [31:0] res;
    start_op(f3, a, b, lat, bc, res);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, res, exp_res);
    consume();
  endtask

  initial begin
    int lat, bc, seen;
    logic [31:0] res;

    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);

    // 1: DIV 20 / -3
    start_op(F3_DIV, 32'd20, 32'hFFFFFFFD, lat, bc, res);
    check("t1_lat", lat, 33);
    check("t1_busy_cycles", bc, 33);
    check("t1_res", res, 32'hFFFFFFFA);
    check("t1_busy_in_done", {31'b0, busy}, 32'd0);
    consume();
    check("t1_done_dropped", {31'b0, done}, 32'd0);

    // 2: divide by zero
    run_op("t2_divu0", F3_DIVU, 32'd7, 32'd0, 1, 32'hFFFFFFFF);
    run_op("t2_remu0", F3_REMU, 32'd7, 32'd0, 1, 32'd7);
    run_op("t2_div0",  F3_DIV,  32'hFFFFFFF9, 32'd0, 1, 32'hFFFFFFFF);

    // 3: signed overflow
    run_op("t3_div_ovf", F3_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
    run_op("t3_rem_ovf", F3_REM, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0);

    // 4: cache hit after t1, signedness mismatch misses
    run_op("t4_rem_hit",   F3_REM,  32'd20, 32'hFFFFFFFD, 1, 32'd2);
    run_op("t4_remu_miss", F3_REMU, 32'd20, 32'hFFFFFFFD, 33, 32'd20);

    // Extra sign patterns: negative dividend, large unsigned
    run_op("neg_div", F3_DIV, 32'hFFFFFF9C, 32'd7, 33, 32'hFFFFFFF2);
    run_op("neg_rem_hit", F3_REM, 32'hFFFFFF9C, 32'd7, 1, 32'hFFFFFFFE);
    run_op("both_neg", F3_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 33, 32'd14);
    run_op("both_neg_rem", F3_REM, 32'hFFFFFF9C, 32'hFFFFFFF9, 1, 32'hFFFFFFFE);

    // 5: flush at RUN cycle 10
    funct3 = F3_DIVU;
    rs1 = 32'd100;
    rs2 = 32'd7;
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_busy_after_flush", {31'b0, busy}, 32'd0);
    check("t5_done_after_flush", {31'b0, done}, 32'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (done) seen = 1;
    end
    check("t5_no_done", seen, 0);
    run_op("t5_divu_full", F3_DIVU, 32'd100, 32'd7, 33, 32'd14);
    run_op("t5_remu_hit",  F3_REMU, 32'd100, 32'd7, 1, 32'd2);

    // 6a: stall in DONE, repeated req ignored
    stall = 1'b1;
    start_op(F3_DIV, 32'hFFFFFF9C, 32'd3, lat, bc, res);
    check("t6_lat", lat, 33);
    check("t6_res", res, 32'hFFFFFFDF);
    req = 1'b1;
    funct3 = F3_DIVU;
    rs1 = 32'd9;
    rs2 = 32'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t6_stall_done_%0d", i), {31'b0, done}, 32'd1);
      check($sformatf("t6_stall_res_%0d", i), result, 32'hFFFFFFDF);
    end
    req = 1'b0;
    consume();
    check("t6_done_after_consume", {31'b0, done}, 32'd0);
    check("t6_busy_after_consume", {31'b0, busy}, 32'd0);
    run_op("t6_rem_hit", F3_REM, 32'hFFFFFF9C, 32'd3, 1, 32'hFFFFFFFF);

    // 6b: reset mid-RUN clears outputs and the cache
    funct3 = F3_DIVU;
    rs1 = 32'hFFFFFFFF;
    rs2 = 32'd16;
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    check("t6_rst_done", {31'b0, done}, 32'd0);
    check("t6_rst_result", result, 32'd0);
    run_op("t6_post_rst_miss", F3_REM, 32'hFFFFFF9C, 32'd3, 33, 32'hFFFFFFFF);
    run_op("big_divu", F3_DIVU, 32'hFFFFFFFF, 32'd16, 33, 32'h0FFFFFFF);
    run_op("big_remu_hit", F3_REMU, 32'hFFFFFFFF, 32'd16, 1, 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
